// File: rtl/mem_lock_arbiter.sv
// Round-robin memory lock arbiter: one client at a time owns a shared word
// memory, with single-cycle or locked multi-cycle tenures.
module mem_lock_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ID_WIDTH  = 8,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS*ID_WIDTH-1:0] req_issue_id,
  input  logic [NUM_PORTS-1:0]          release_lock,
  input  logic [NUM_PORTS*30-1:0]       addr,
  input  logic [NUM_PORTS*32-1:0]       wdata,
  input  logic [NUM_PORTS-1:0]          wen,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [NUM_PORTS*32-1:0]       rdata,
  output logic [ID_WIDTH-1:0]           owner_issue_id,
  output logic [31:0]                   grant_count
);

  localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned AW    = 30;
  localparam int unsigned DW    = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     pick;
  logic [PW-1:0]     scan_port;
  logic [PW-1:0]     act_port;
  logic [PW-1:0]     next_ptr;
  logic [31:0]       scan_idx;
  logic              pick_valid;
  logic              active;
  logic              tenure_end;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DW-1:0]     rd_word;
  logic [DW-1:0]     act_wdata;
  logic [DW-1:0]     mem [MEM_WORDS];

  // First requester at or after rr_ptr, wrapping modulo NUM_PORTS
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    scan_idx   = '0;
    scan_port  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      scan_idx = 32'(rr_ptr) + i;
      if (scan_idx >= NUM_PORTS) begin
        scan_idx = scan_idx - NUM_PORTS;
      end
      scan_port = PW'(scan_idx);
      if (!pick_valid && req[scan_port]) begin
        pick_valid = 1'b1;
        pick       = scan_port;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_valid && !release_lock[pick]) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (!req[owner] || release_lock[owner]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: grant and read mux are combinational and forced low during reset
  always_comb begin
    act_port   = (state == LOCKED) ? owner : pick;
    active     = rst_n && ((state == LOCKED) ? req[owner] : pick_valid);
    tenure_end = rst_n && ((state == LOCKED) ? (!req[owner] || release_lock[owner])
                                             : (pick_valid && release_lock[pick]));
    next_ptr   = (act_port == PW'(NUM_PORTS - 1)) ? '0 : act_port + PW'(1);
    mem_idx    = addr[32'(act_port) * AW +: IDX_W];
    act_wdata  = wdata[32'(act_port) * DW +: DW];
    mem_we     = active && wen[act_port];
    rd_word    = mem[mem_idx];
    grant      = '0;
    rdata      = '0;
    if (active) begin
      grant[act_port]                    = 1'b1;
      rdata[32'(act_port) * DW +: DW]    = rd_word;
    end
  end

  // Owner, round-robin pointer, issue ID and tenure counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      owner          <= '0;
      owner_issue_id <= '0;
      grant_count    <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        owner          <= pick;
        owner_issue_id <= req_issue_id[32'(pick) * ID_WIDTH +: ID_WIDTH];
      end
      if (tenure_end) begin
        rr_ptr      <= next_ptr;
        grant_count <= grant_count + 32'd1;
      end
    end
  end

  // Memory array is intentionally not reset; writes are blocked while rst_n is low
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= act_wdata;
    end
  end

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Self-checking bench for mem_lock_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_mem_lock_arbiter;

  localparam int unsigned NP  = 4;
  localparam int unsigned IDW = 8;
  localparam int unsigned MW  = 1024;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req;
  logic [NP*IDW-1:0] req_issue_id;
  logic [NP-1:0]     release_lock;
  logic [NP*30-1:0]  addr;
  logic [NP*32-1:0]  wdata;
  logic [NP-1:0]     wen;
  logic [NP-1:0]     grant;
  logic [NP*32-1:0]  rdata;
  logic [IDW-1:0]    owner_issue_id;
  logic [31:0]       grant_count;

  mem_lock_arbiter #(.NUM_PORTS(NP), .ID_WIDTH(IDW), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_issue_id(req_issue_id),
    .release_lock(release_lock), .addr(addr), .wdata(wdata), .wen(wen),
    .grant(grant), .rdata(rdata), .owner_issue_id(owner_issue_id),
    .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  rel;
    logic [3:0]  exp_grant;
    logic [31:0] exp_cnt;
    logic [7:0]  exp_oid;
  } vec_t;

  vec_t tbl [18];

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: owner (-1 = none), pointer, tenure count, last ID, sparse memory
  int          m_owner;
  int          m_ptr;
  int          m_g;
  logic [31:0] m_cnt;
  logic [7:0]  m_oid;
  logic [31:0] m_mem [int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int word_of(input int p);
    logic [29:0] a;
    a = addr[p*30 +: 30];
    return int'(a % 30'(MW));
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = '0;
    m_oid   = '0;
  endtask

  // Mid-cycle: evaluate the model's grant and compare every output
  task automatic sample();
    @(negedge clk);
    if (!rst_n) model_reset();
    m_g = -1;
    if (rst_n) begin
      if (m_owner >= 0) begin
        if (req[m_owner]) m_g = m_owner;
      end else begin
        for (int k = 0; k < NP; k++) begin
          int p;
          p = (m_ptr + k) % NP;
          if (m_g < 0 && req[p]) m_g = p;
        end
      end
    end
    check("grant", 64'(grant), (m_g >= 0) ? (64'(1) << m_g) : 64'(0));
    check("owner_issue_id", 64'(owner_issue_id), 64'(m_oid));
    check("grant_count", 64'(grant_count), 64'(m_cnt));
    for (int p = 0; p < NP; p++) begin
      if (p == m_g) begin
        if (m_mem.exists(word_of(p)))
          check($sformatf("rdata[%0d]", p), 64'(rdata[p*32 +: 32]), 64'(m_mem[word_of(p)]));
      end else begin
        check($sformatf("rdata[%0d]", p), 64'(rdata[p*32 +: 32]), 64'(0));
      end
    end
  endtask

  // Clock edge: apply the tenure rules to the model
  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      if (m_g >= 0 && wen[m_g]) m_mem[word_of(m_g)] = wdata[m_g*32 +: 32];
      if (m_owner >= 0) begin
        if (!req[m_owner] || release_lock[m_owner]) begin
          m_ptr   = (m_owner + 1) % NP;
          m_cnt   = m_cnt + 32'd1;
          m_owner = -1;
        end
      end else if (m_g >= 0) begin
        m_oid = req_issue_id[m_g*8 +: 8];
        if (release_lock[m_g]) begin
          m_ptr = (m_g + 1) % NP;
          m_cnt = m_cnt + 32'd1;
        end else begin
          m_owner = m_g;
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] rl, input logic [3:0] w);
    req          = r;
    release_lock = rl;
    wen          = w;
  endtask

  initial begin
    // Directed sequence from reset: round-robin, locked tenure, abort, rotation
    tbl[0]  = '{4'b0101, 4'b0101, 4'b0001, 32'd0,  8'h00};
    tbl[1]  = '{4'b0100, 4'b0100, 4'b0100, 32'd1,  8'h10};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 32'd2,  8'h12};
    tbl[3]  = '{4'b0001, 4'b0001, 4'b0001, 32'd2,  8'h12};
    tbl[4]  = '{4'b1010, 4'b0000, 4'b0010, 32'd3,  8'h10};
    tbl[5]  = '{4'b1010, 4'b0000, 4'b0010, 32'd3,  8'h11};
    tbl[6]  = '{4'b1010, 4'b0000, 4'b0010, 32'd3,  8'h11};
    tbl[7]  = '{4'b1010, 4'b0010, 4'b0010, 32'd3,  8'h11};
    tbl[8]  = '{4'b1000, 4'b1000, 4'b1000, 32'd4,  8'h11};
    tbl[9]  = '{4'b0100, 4'b0000, 4'b0100, 32'd5,  8'h13};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 32'd5,  8'h12};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 32'd6,  8'h12};
    tbl[12] = '{4'b1000, 4'b1000, 4'b1000, 32'd6,  8'h12};
    tbl[13] = '{4'b1111, 4'b1111, 4'b0001, 32'd7,  8'h13};
    tbl[14] = '{4'b1111, 4'b1111, 4'b0010, 32'd8,  8'h10};
    tbl[15] = '{4'b1111, 4'b1111, 4'b0100, 32'd9,  8'h11};
    tbl[16] = '{4'b1111, 4'b1111, 4'b1000, 32'd10, 8'h12};
    tbl[17] = '{4'b1111, 4'b1111, 4'b0001, 32'd11, 8'h13};

    rst_n        = 1'b0;
    req_issue_id = {8'h13, 8'h12, 8'h11, 8'h10};
    addr         = '0;
    wdata        = '0;
    drive(4'b0101, 4'b0000, 4'b0101);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    sample();
    check("reset_grant", 64'(grant), 64'(0));
    check("reset_rdata", 64'(rdata[63:0]) | 64'(rdata[127:64]), 64'(0));
    advance();
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].req, tbl[i].rel, 4'b0000);
      sample();
      check($sformatf("tbl%0d_grant", i), 64'(grant), 64'(tbl[i].exp_grant));
      check($sformatf("tbl%0d_count", i), 64'(grant_count), 64'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_oid", i), 64'(owner_issue_id), 64'(tbl[i].exp_oid));
      advance();
    end

    // Write through port 0, read back through port 1 with an aliased address
    drive(4'b0001, 4'b0001, 4'b0001);
    addr[29:0]  = 30'd5;
    wdata[31:0] = 32'hDEADBEEF;
    sample();
    advance();
    drive(4'b0010, 4'b0010, 4'b0000);
    addr[59:30] = 30'(5 + MW);
    sample();
    check("alias_rdata1", 64'(rdata[63:32]), 64'h0000_0000_DEAD_BEEF);
    check("alias_rdata0", 64'(rdata[31:0]), 64'(0));
    advance();

    // Reset mid-tenure with a pending write on the owner
    drive(4'b0100, 4'b0000, 4'b0000);
    sample();
    advance();
    addr[89:60]  = 30'd5;
    wdata[95:64] = 32'h1234_5678;
    drive(4'b0100, 4'b0000, 4'b0100);
    rst_n = 1'b0;
    #1;
    check("rst_grant_now", 64'(grant), 64'(0));
    check("rst_rdata2_now", 64'(rdata[95:64]), 64'(0));
    sample();
    advance();
    rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 4'b0000);
    sample();
    check("rst_count_after", 64'(grant_count), 64'(0));
    advance();
    drive(4'b0001, 4'b0001, 4'b0000);
    sample();
    check("rst_no_write", 64'(rdata[31:0]), 64'h0000_0000_DEAD_BEEF);
    advance();

    // Randomized traffic with occasional reset pulses
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int p = 0; p < NP; p++) begin
        req[p]                 = ($urandom_range(0, 9) < 6);
        release_lock[p]        = ($urandom_range(0, 9) < 3);
        wen[p]                 = 1'($urandom_range(0, 1));
        addr[p*30 +: 30]       = {20'($urandom), 10'($urandom_range(0, 15))};
        wdata[p*32 +: 32]      = $urandom;
        req_issue_id[p*8 +: 8] = 8'($urandom);
      end
      sample();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_lock_arbiter.md
MEM_LOCK_ARBITER -- requirements
Module: mem_lock_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of SIC memory client ports; range 2..8.
REQ-002 Parameter ID_WIDTH, default 8, width of issue IDs.
REQ-003 Parameter MEM_WORDS, default 1024, data memory depth in 32-bit words; power of 2.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  NUM_PORTS  per-port memory lock request.
REQ-007 req_issue_id  in  NUM_PORTS*ID_WIDTH  per-port issue ID; port p occupies bits [p*ID_WIDTH +: ID_WIDTH].
REQ-008 release_lock  in  NUM_PORTS  per-port lock release, sampled only from the current grantee.
REQ-009 addr  in  NUM_PORTS*30  per-port word address.
REQ-010 wdata  in  NUM_PORTS*32  per-port write data.
REQ-011 wen  in  NUM_PORTS  per-port write enable.
REQ-012 grant  out  NUM_PORTS  one-hot-or-zero memory grant.
REQ-013 rdata  out  NUM_PORTS*32  per-port read data.
REQ-014 owner_issue_id  out  ID_WIDTH  registered issue ID of the last granted request.
REQ-015 grant_count  out  32  registered count of completed lock tenures.

Function
REQ-016 FSM states: IDLE (no owner), LOCKED (owner register valid).
REQ-017 IDLE: when any req is high, the arbiter SHALL assert grant combinationally in the same cycle to the first requesting port found scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
REQ-018 IDLE grant with release_lock from the same port in that cycle: single-cycle tenure; the FSM stays IDLE.
REQ-019 IDLE grant without release_lock: the FSM SHALL enter LOCKED with owner = granted port.
REQ-020 LOCKED: grant SHALL be asserted to the owner only, for as long as owner req is high; all other ports SHALL see grant=0.
REQ-021 LOCKED with owner release_lock=1: grant stays high that cycle; the FSM SHALL move to IDLE next cycle.
REQ-022 LOCKED with owner req=0 (aborted client): grant=0 that cycle; the FSM SHALL move to IDLE next cycle; the tenure counts as completed.
REQ-023 On every tenure end (REQ-018/021/022), rr_ptr SHALL become (owner+1) mod NUM_PORTS and grant_count SHALL increment, wrapping at 2^32.
REQ-024 owner_issue_id SHALL load req_issue_id of the granted port on the first grant cycle of each tenure.
REQ-025 release_lock, wen, addr and wdata from non-granted ports SHALL be ignored.
REQ-026 Memory index = granted port's addr modulo MEM_WORDS (low log2(MEM_WORDS) bits); upper address bits are ignored.
REQ-027 Read: asynchronous; rdata of the granted port SHALL equal mem[index] in the same cycle; rdata of all other ports SHALL be 0.
REQ-028 Write: when the granted port has wen=1, mem[index] SHALL be updated with wdata at the clock edge ending the cycle; same-cycle rdata shows the old value.
REQ-029 At most one memory access per cycle; there is no write when grant=0.
REQ-030 A port whose req falls before it is granted is dropped with no side effects.

Reset
REQ-031 Asynchronous reset SHALL force FSM=IDLE, rr_ptr=0, owner=0, owner_issue_id=0, grant_count=0.
REQ-032 During reset, grant SHALL be 0 and all rdata SHALL be 0.
REQ-033 Memory contents are not reset.
REQ-034 Reset asserted mid-tenure SHALL discard the lock; a write in the reset cycle SHALL NOT occur.

Verification
REQ-035 Ports 0 and 2 both request in IDLE with rr_ptr=0 and same-cycle release -> port 0 granted in that cycle; next cycle port 2 granted; grant_count=2.
REQ-036 Port 1 request without release, held 3 cycles, then release -> grant[1]=1 for 4 cycles; port 3 requesting throughout sees no grant until the cycle after release.
REQ-037 Port 0 writes 0xDEADBEEF to addr 5, then port 1 reads addr 5+MEM_WORDS -> rdata[1]=0xDEADBEEF and rdata[0]=0 during port 1's grant.
REQ-038 Owner drops req while LOCKED -> grant=0 that cycle; FSM IDLE next cycle; grant_count increments by 1.
REQ-039 Assert rst_n=0 mid-tenure with wen=1 -> grant=0 immediately, no memory update, grant_count=0 after reset.
REQ-040 All four ports request continuously with single-cycle tenures -> grants rotate 0,1,2,3,0; owner_issue_id tracks each granted port's ID.
